time_set_ctrl: RTL and testbench
================================

// Module: time_set_ctrl
// PURPOSE
// Button-driven time-setting controller for the `display` clock core. Turns two raw
// pushbuttons (MODE, INC) into a one-cycle `set` strobe with the `set_hours`/`set_minutes`
// value that `display` loads. Sits between the board buttons and `display`. It reads back
// the running time so editing starts from the current value. It exports field/blink
// status for the digit drivers.
// PARAMETERS
// DEBOUNCE_CYCLES  16      stable-level cycles before a button change is accepted (>=2)
// TIMEOUT_CYCLES   4096    idle cycles in an edit state before abort to RUN (no commit)
// BLINK_CYCLES     256     half-period of blink output while editing
// PORTS
// clk          in   1  system clock, same clock as `display`
// reset        in   1  asynchronous, active-high reset
// btn_mode     in   1  raw MODE pushbutton, asynchronous, active-high
// btn_inc      in   1  raw INC pushbutton, asynchronous, active-high
// cur_hours    in   5  running hours from display (0..23)
// cur_minutes  in   7  running minutes from display (0..59)
// set          out  1  one-cycle load strobe to display
// set_hours    out  5  hours value to load, valid while set=1 (held otherwise)
// set_minutes  out  7  minutes value to load, valid while set=1 (held otherwise)
// edit_field   out  2  00=none, 01=hours, 10=minutes
// blink        out  1  toggles every BLINK_CYCLES while editing; 0 in RUN
// BEHAVIOUR
// - Reset (async assert, sync release): state=RUN. set=0, set_hours=0, set_minutes=0,
//   edit_field=00, blink=0. Debouncers report released; timers cleared.
// - Each button: 2-FF synchronizer. Then debounce: the accepted level changes only after
//   DEBOUNCE_CYCLES consecutive equal synced samples. A 0->1 accepted edge gives a 1-cycle
//   press pulse. Latency from raw edge to pulse = 2 + DEBOUNCE_CYCLES cycles. Holding a
//   button gives exactly one pulse (no auto-repeat).
// - FSM states RUN, EDIT_H, EDIT_M, COMMIT:
//   RUN:    mode_p -> shadow_h<=cur_hours, shadow_m<=cur_minutes, go EDIT_H. inc_p ignored.
//   EDIT_H: inc_p -> shadow_h = (shadow_h==23) ? 0 : shadow_h+1. mode_p -> EDIT_M.
//   EDIT_M: inc_p -> shadow_m = (shadow_m==59) ? 0 : shadow_m+1. mode_p -> COMMIT.
//   COMMIT: set=1 for exactly this cycle, set_hours=shadow_h, set_minutes=shadow_m;
//           next state RUN unconditionally. Button pulses in this cycle are dropped.
// - set_hours/set_minutes are registered from the shadow regs and track them in all
//   states. display samples them only when set=1.
// - mode_p and inc_p in the same cycle: mode wins, inc discarded.
// - Timeout: the idle counter clears on any press pulse and on entry to EDIT_H. While in
//   EDIT_H/EDIT_M it increments. On reaching TIMEOUT_CYCLES-1 -> RUN, set stays 0, and the
//   edit is discarded.
// - edit_field = 01 in EDIT_H, 10 in EDIT_M, 00 otherwise. The blink counter resets on
//   entry to RUN.
// - Shadow arithmetic is unsigned at field width. Shadow values can never exceed 23/59.
// - Reset mid-edit: returns to RUN with no set strobe and the shadow regs cleared.
// STRUCTURE
// - clock_pkg: state enum {RUN,EDIT_H,EDIT_M,COMMIT}; HRS_W=5, MIN_W=7, HRS_MAX=23,
//   MIN_MAX=59; edit_field encodings.
// - Sub-module btn_debounce (sync + debounce + rise pulse, param DEBOUNCE_CYCLES),
//   instantiated twice. The FSM, shadow regs, timeout and blink stay in time_set_ctrl.
// TESTING (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64, BLINK_CYCLES=8; bench pairs with display)
// - Reset asserted mid-cycle -> all outputs 0 immediately. Release -> RUN, no set pulse.
// - Bounce: 3-cycle glitches on btn_mode, then a clean 20-cycle hold -> exactly one press.
//   EDIT_H is entered 6 cycles after the clean edge.
// - cur=10:15. MODE, INC x3, MODE, INC x45, MODE -> one set pulse with 13:00.
//   display reads 13:00 after the strobe.
// - Wrap: cur=23:59. MODE, INC, MODE, INC, MODE -> set with 0:00.
// - MODE then no press for 64 cycles -> back to RUN, edit_field=00, set never asserted.
// - MODE and INC accepted in the same cycle in EDIT_H -> EDIT_M, hours unchanged.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and field limits for the clock time-setting path.
// Field widths match the display core's hours/minutes ports.
package clock_pkg;

    localparam int unsigned HRS_W = 5;
    localparam int unsigned MIN_W = 7;

    localparam logic [HRS_W-1:0] HRS_MAX = 5'd23;
    localparam logic [MIN_W-1:0] MIN_MAX = 7'd59;

    typedef enum logic [1:0] {
        RUN,
        EDIT_H,
        EDIT_M,
        COMMIT
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE    = 2'b00,
        FIELD_HOURS   = 2'b01,
        FIELD_MINUTES = 2'b10
    } field_e;

    // Out-of-range values also wrap to zero so a shadow can never escape its legal range.
    function automatic logic [HRS_W-1:0] next_hours(input logic [HRS_W-1:0] h);
        return (h >= HRS_MAX) ? '0 : h + HRS_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] next_minutes(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stable-level debounce and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic press_p
);
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             synced;

    assign synced = sync_q[1];

    // The sample that completes the run is the accepting one, so the
    // counter only has to reach DEBOUNCE_CYCLES-1 before the flip.
    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        level_d = level_q;
        cnt_d   = '0;
        accept  = (synced != level_q) && (cnt_q == CNT_LAST);
        if (synced != level_q) begin
            if (accept) begin
                level_d = synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_p = accept & synced;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: MODE/INC presses edit a shadow copy
// of the running time, then strobe it into the display core.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 4096,
    parameter int unsigned BLINK_CYCLES    = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_mode,
    input  logic             btn_inc,
    input  logic [HRS_W-1:0] cur_hours,
    input  logic [MIN_W-1:0] cur_minutes,
    output logic             set,
    output logic [HRS_W-1:0] set_hours,
    output logic [MIN_W-1:0] set_minutes,
    output logic [1:0]       edit_field,
    output logic             blink
);
    localparam int unsigned IDLE_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

    logic mode_p;
    logic inc_p;

    state_e             state_q, state_d;
    logic [HRS_W-1:0]   shadow_h_q, shadow_h_d;
    logic [MIN_W-1:0]   shadow_m_q, shadow_m_d;
    logic [HRS_W-1:0]   set_hours_q, set_hours_d;
    logic [MIN_W-1:0]   set_minutes_q, set_minutes_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic               editing_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_mode),
        .press_p (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_inc),
        .press_p (inc_p)
    );

    // Edit FSM: MODE outranks INC, any pulse restarts the idle timer.
    always_comb begin
        state_d    = state_q;
        shadow_h_d = shadow_h_q;
        shadow_m_d = shadow_m_q;
        idle_d     = idle_q;
        unique case (state_q)
            RUN: begin
                idle_d = '0;
                if (mode_p) begin
                    shadow_h_d = cur_hours;
                    shadow_m_d = cur_minutes;
                    state_d    = EDIT_H;
                end
            end
            EDIT_H: begin
                if (mode_p) begin
                    state_d = EDIT_M;
                    idle_d  = '0;
                end else if (inc_p) begin
                    shadow_h_d = next_hours(shadow_h_q);
                    idle_d     = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = RUN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            EDIT_M: begin
                if (mode_p) begin
                    state_d = COMMIT;
                    idle_d  = '0;
                end else if (inc_p) begin
                    shadow_m_d = next_minutes(shadow_m_q);
                    idle_d     = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d = RUN;
                    idle_d  = '0;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            COMMIT: begin
                state_d = RUN;
                idle_d  = '0;
            end
            default: begin
                state_d = RUN;
                idle_d  = '0;
            end
        endcase
    end

    // Blink is keyed off the next state so it is already low in the first RUN cycle.
    always_comb begin
        editing_d   = (state_d == EDIT_H) || (state_d == EDIT_M);
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (editing_d) begin
            blink_d = blink_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_comb begin
        set_hours_d   = shadow_h_q;
        set_minutes_d = shadow_m_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            shadow_h_q    <= '0;
            shadow_m_q    <= '0;
            set_hours_q   <= '0;
            set_minutes_q <= '0;
            idle_q        <= '0;
            blink_cnt_q   <= '0;
            blink_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_h_q    <= shadow_h_d;
            shadow_m_q    <= shadow_m_d;
            set_hours_q   <= set_hours_d;
            set_minutes_q <= set_minutes_d;
            idle_q        <= idle_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_q       <= blink_d;
        end
    end

    always_comb begin
        set         = (state_q == COMMIT);
        set_hours   = set_hours_q;
        set_minutes = set_minutes_q;
        blink       = blink_q;
        unique case (state_q)
            EDIT_H:  edit_field = FIELD_HOURS;
            EDIT_M:  edit_field = FIELD_MINUTES;
            default: edit_field = FIELD_NONE;
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a cycle-level behavioural model
// of the button/edit rules.
module tb_time_set_ctrl;
    localparam int unsigned DB = 4;
    localparam int unsigned TO = 64;
    localparam int unsigned BL = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hours = '0;
    logic [6:0] cur_minutes = '0;
    logic       set;
    logic [4:0] set_hours;
    logic [6:0] set_minutes;
    logic [1:0] edit_field;
    logic       blink;

    int vectors = 0;
    int miscompares = 0;

    time_set_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO),
        .BLINK_CYCLES   (BL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hours  (cur_hours),
        .cur_minutes(cur_minutes),
        .set        (set),
        .set_hours  (set_hours),
        .set_minutes(set_minutes),
        .edit_field (edit_field),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    // Model: 0=run 1=hours 2=minutes 3=commit; raw sample history per button.
    int m_st, m_sh, m_sm, m_quiet, m_edit_n, m_sets, m_last_h, m_last_m;
    bit m_lvl_mode, m_lvl_inc;
    bit q_mode[$];
    bit q_inc[$];
    int dut_sets = 0;
    int dut_last_h = -1;
    int dut_last_m = -1;

    function automatic int m_field();
        return (m_st == 1) ? 1 : (m_st == 2) ? 2 : 0;
    endfunction

    function automatic int m_blink();
        return (m_edit_n / BL) % 2;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sh = 0; m_sm = 0; m_quiet = 0; m_edit_n = 0;
        m_lvl_mode = 0; m_lvl_inc = 0;
        q_mode.delete(); q_inc.delete();
        for (int unsigned k = 0; k <= DB; k++) begin
            q_mode.push_back(1'b0);
            q_inc.push_back(1'b0);
        end
    endtask

    task automatic model_step(input bit bm, input bit bi);
        bit chg_m = 1, chg_i = 1, mp, ip;
        for (int unsigned k = 0; k < DB; k++) begin
            if (q_mode[k] == m_lvl_mode) chg_m = 0;
            if (q_inc[k] == m_lvl_inc) chg_i = 0;
        end
        mp = chg_m && !m_lvl_mode;
        ip = chg_i && !m_lvl_inc;
        if (chg_m) m_lvl_mode = !m_lvl_mode;
        if (chg_i) m_lvl_inc = !m_lvl_inc;
        q_mode.push_back(bm); void'(q_mode.pop_front());
        q_inc.push_back(bi);  void'(q_inc.pop_front());
        case (m_st)
            0: if (mp) begin m_sh = cur_hours; m_sm = cur_minutes; m_st = 1; m_quiet = 0; end
            1, 2: begin
                if (mp) begin m_st = m_st + 1; m_quiet = 0; end
                else if (ip) begin
                    if (m_st == 1) m_sh = (m_sh + 1) % 24; else m_sm = (m_sm + 1) % 60;
                    m_quiet = 0;
                end else begin
                    m_quiet++;
                    if (m_quiet == TO) m_st = 0;
                end
            end
            default: m_st = 0;
        endcase
        m_edit_n = (m_st == 1 || m_st == 2) ? m_edit_n + 1 : 0;
        if (m_st == 3) begin m_sets++; m_last_h = m_sh; m_last_m = m_sm; end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(btn_mode, btn_inc);
        @(negedge clk);
        if (set === 1'b1) begin
            dut_sets++;
            dut_last_h = int'(set_hours);
            dut_last_m = int'(set_minutes);
        end
    endtask

    task automatic press(input bit bm, input bit bi, input int hold, input int gap);
        btn_mode = bm; btn_inc = bi;
        repeat (hold) tick();
        btn_mode = 1'b0; btn_inc = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        int s0;
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({set, set_hours, set_minutes, edit_field, blink} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h expected 0", {set, set_hours, set_minutes, edit_field, blink});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        model_reset();
        s0 = dut_sets;
        repeat (10) tick();
        vectors++;
        if (dut_sets != s0 || edit_field !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: sets %0d field %b expected 0 / 00", dut_sets - s0, edit_field);
        end
        cur_hours = 5'($urandom_range(1, 23)); cur_minutes = 7'($urandom_range(1, 59));
        press(1, 0, 7, 6);
        press(0, 1, 7, 6);
        @(posedge clk); #2 reset = 1'b1; #1;
        vectors++;
        if ({set, set_hours, set_minutes, edit_field, blink} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_edit: got %h expected 0", {set, set_hours, set_minutes, edit_field, blink});
        end
        @(negedge clk) reset = 1'b0;
        model_reset();
        s0 = dut_sets;
        repeat (20) tick();
        vectors++;
        if (dut_sets != s0 || edit_field !== 2'b00 || set_hours !== 5'd0) begin
            miscompares++;
            $display("FAIL reset_mid_edit_after: sets %0d field %b hours %0d expected 0/00/0", dut_sets - s0, edit_field, set_hours);
        end
    endtask

    task automatic test_bounce();
        int s0 = dut_sets;
        int exp_f;
        cur_hours = 5'($urandom_range(0, 23)); cur_minutes = 7'($urandom_range(0, 59));
        for (int unsigned g = 0; g < 4; g++) begin
            btn_mode = 1'b1;
            repeat ($urandom_range(1, 3)) tick();
            btn_mode = 1'b0;
            repeat ($urandom_range(3, 5)) tick();
            vectors++;
            if (edit_field !== 2'b00) begin
                miscompares++;
                $display("FAIL bounce_glitch: field %b expected 00", edit_field);
            end
        end
        repeat (6) tick();
        btn_mode = 1'b1;
        for (int unsigned k = 1; k <= 20; k++) begin
            tick();
            exp_f = (k < 6) ? 0 : 1;
            vectors++;
            if (edit_field !== 2'(exp_f) || blink !== 1'(m_blink())) begin
                miscompares++;
                $display("FAIL bounce_clean k=%0d: field %b blink %b expected %0d %0d", k, edit_field, blink, exp_f, m_blink());
            end
        end
        btn_mode = 1'b0;
        repeat (8) tick();
        vectors++;
        if (edit_field !== 2'b01) begin
            miscompares++;
            $display("FAIL bounce_single_press: field %b expected 01", edit_field);
        end
        press(1, 0, 7, 6);
        press(1, 0, 7, 6);
        vectors++;
        if (dut_sets - s0 != 1 || dut_last_h != int'(cur_hours) || dut_last_m != int'(cur_minutes)) begin
            miscompares++;
            $display("FAIL bounce_commit: sets %0d got %0d:%0d expected 1 %0d:%0d", dut_sets - s0, dut_last_h, dut_last_m, cur_hours, cur_minutes);
        end
    endtask

    task automatic test_edit(input int h0, input int mn0, input int n_h, input int n_m, input int eh, input int em);
        int s0 = dut_sets;
        cur_hours = 5'(h0); cur_minutes = 7'(mn0);
        press(1, 0, $urandom_range(6, 9), $urandom_range(6, 9));
        vectors++;
        if (edit_field !== 2'b01) begin
            miscompares++;
            $display("FAIL edit_enter_h: field %b expected 01", edit_field);
        end
        repeat (n_h) press(0, 1, $urandom_range(6, 9), $urandom_range(6, 9));
        press(1, 0, $urandom_range(6, 9), $urandom_range(6, 9));
        vectors++;
        if (edit_field !== 2'b10) begin
            miscompares++;
            $display("FAIL edit_enter_m: field %b expected 10", edit_field);
        end
        repeat (n_m) press(0, 1, $urandom_range(6, 9), $urandom_range(6, 9));
        press(1, 0, 6, 8);
        vectors++;
        if (dut_sets - s0 != 1 || dut_last_h != eh || dut_last_m != em || edit_field !== 2'b00) begin
            miscompares++;
            $display("FAIL edit_commit %0d:%0d: sets %0d got %0d:%0d field %b expected 1 %0d:%0d 00",
                     h0, mn0, dut_sets - s0, dut_last_h, dut_last_m, edit_field, eh, em);
        end
    endtask

    task automatic test_timeout();
        int s0 = dut_sets;
        int exp_f;
        cur_hours = 5'($urandom_range(0, 23)); cur_minutes = 7'($urandom_range(0, 59));
        btn_mode = 1'b1;
        repeat (6) tick();
        btn_mode = 1'b0;
        for (int unsigned k = 1; k <= 70; k++) begin
            tick();
            exp_f = (k < TO) ? 1 : 0;
            vectors++;
            if (edit_field !== 2'(exp_f) || blink !== 1'(m_blink())) begin
                miscompares++;
                $display("FAIL timeout k=%0d: field %b blink %b expected %0d %0d", k, edit_field, blink, exp_f, m_blink());
            end
        end
        vectors++;
        if (dut_sets != s0 || blink !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_no_set: sets %0d blink %b expected 0 0", dut_sets - s0, blink);
        end
    endtask

    task automatic test_simultaneous();
        int s0 = dut_sets;
        cur_hours = 5'($urandom_range(0, 22)); cur_minutes = 7'($urandom_range(0, 59));
        press(1, 0, 7, 7);
        press(1, 1, 7, 7);
        vectors++;
        if (edit_field !== 2'b10) begin
            miscompares++;
            $display("FAIL simul_field: field %b expected 10", edit_field);
        end
        press(1, 0, 7, 8);
        vectors++;
        if (dut_sets - s0 != 1 || dut_last_h != int'(cur_hours) || dut_last_m != int'(cur_minutes)) begin
            miscompares++;
            $display("FAIL simul_hours: sets %0d got %0d:%0d expected 1 %0d:%0d", dut_sets - s0, dut_last_h, dut_last_m, cur_hours, cur_minutes);
        end
    endtask

    task automatic test_random();
        int s0, ms0, kind;
        for (int unsigned r = 0; r < 8; r++) begin
            s0 = dut_sets; ms0 = m_sets;
            cur_hours = 5'($urandom_range(0, 23)); cur_minutes = 7'($urandom_range(0, 59));
            for (int unsigned p = 0; p < $urandom_range(1, 20); p++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) begin
                    btn_inc = 1'b1; repeat ($urandom_range(1, 3)) tick(); btn_inc = 1'b0; repeat (4) tick();
                end else if (kind == 1) begin
                    repeat ($urandom_range(40, 70)) tick();
                end else begin
                    press(kind < 5, kind >= 4, $urandom_range(6, 9), $urandom_range(6, 9));
                end
                vectors++;
                if (edit_field !== 2'(m_field()) || blink !== 1'(m_blink())) begin
                    miscompares++;
                    $display("FAIL random_state r=%0d: field %b blink %b expected %0d %0d", r, edit_field, blink, m_field(), m_blink());
                end
            end
            repeat (80) tick();
            vectors++;
            if (dut_sets - s0 != m_sets - ms0 || dut_last_h != m_last_h || dut_last_m != m_last_m || edit_field !== 2'b00) begin
                miscompares++;
                $display("FAIL random_sets r=%0d: sets %0d last %0d:%0d field %b expected %0d %0d:%0d 00",
                         r, dut_sets - s0, dut_last_h, dut_last_m, edit_field, m_sets - ms0, m_last_h, m_last_m);
            end
        end
    endtask

    initial begin
        m_sets = 0; m_last_h = -1; m_last_m = -1;
        model_reset();
        test_reset();
        test_bounce();
        test_edit(10, 15, 3, 45, 13, 0);
        test_edit(23, 59, 1, 1, 0, 0);
        test_timeout();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
